// File: rtl/exp_arbiter.sv
// exp_arbiter: round-robin arbiter that shares one exponential unit among
// four requesters, with a BUSY timeout that completes with an error response.
//
// state | meaning
// IDLE  | waiting for a request; grants the round-robin winner
// START | one-cycle start pulse to the exponential unit
// BUSY  | waiting for exp_done or the timeout
// RESP  | response held until the consumer accepts it
module exp_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [63:0] req_x,
  output logic [3:0]  gnt,
  output logic        exp_start,
  output logic [15:0] exp_x,
  input  logic        exp_done,
  input  logic [1:0]  exp_intpart,
  input  logic [15:0] exp_fracpart,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [1:0]  resp_id,
  output logic [17:0] resp_data,
  output logic        resp_err,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_RESP} state_t;

  localparam logic [7:0] TIMEOUT_TC = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [15:0] exp_x_q, exp_x_d;
  logic [1:0]  cur_id_q, cur_id_d;
  logic [1:0]  last_id_q, last_id_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [17:0] resp_data_q, resp_data_d;
  logic        resp_err_q, resp_err_d;

  logic        win_found;
  logic [1:0]  win_id;
  logic [1:0]  idx;
  logic [7:0]  cnt_inc;
  logic        timeout_hit;

  // Round-robin search starting just after the last served requester.
  always_comb begin
    win_found = 1'b0;
    win_id    = 2'd0;
    idx       = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = last_id_q + 2'(k + 1);
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  // Timeout fires on the BUSY cycle where the incremented count reaches TIMEOUT.
  always_comb begin
    cnt_inc     = cnt_q + 8'd1;
    timeout_hit = (cnt_inc == TIMEOUT_TC);
  end

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      exp_x_q     <= 16'd0;
      cur_id_q    <= 2'd0;
      last_id_q   <= 2'd3;
      cnt_q       <= 8'd0;
      resp_data_q <= 18'd0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_x_q     <= exp_x_d;
      cur_id_q    <= cur_id_d;
      last_id_q   <= last_id_d;
      cnt_q       <= cnt_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  // Next-state logic; done has priority over timeout in BUSY.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (win_found) state_d = S_START;
      S_START: state_d = S_BUSY;
      S_BUSY:  if (exp_done || timeout_hit) state_d = S_RESP;
      S_RESP:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: operand/owner capture, timeout count, result capture.
  always_comb begin
    exp_x_d     = exp_x_q;
    cur_id_d    = cur_id_q;
    last_id_d   = last_id_q;
    cnt_d       = cnt_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          cur_id_d = win_id;
          exp_x_d  = req_x[{win_id, 4'b0000} +: 16];
        end
      end
      S_START: cnt_d = 8'd0;
      S_BUSY: begin
        if (exp_done) begin
          resp_data_d = {exp_intpart, exp_fracpart};
          resp_err_d  = 1'b0;
        end else if (timeout_hit) begin
          resp_data_d = 18'd0;
          resp_err_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RESP: if (resp_ready) last_id_d = cur_id_q;
      default: ;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    gnt        = 4'b0000;
    exp_start  = 1'b0;
    resp_valid = 1'b0;
    busy       = (state_q != S_IDLE);
    case (state_q)
      S_IDLE:  if (win_found) gnt = 4'b0001 << win_id;
      S_START: exp_start = 1'b1;
      S_RESP:  resp_valid = 1'b1;
      default: ;
    endcase
  end

  assign exp_x     = exp_x_q;
  assign resp_id   = cur_id_q;
  assign resp_data = resp_data_q;
  assign resp_err  = resp_err_q;

endmodule
